// File: rtl/fuzzy_pkg.sv
// Shared fixed-point types, widths and FSM encoding for the fuzzy controller output stage.
package fuzzy_pkg;
  typedef logic [15:0]        q1_15_t;
  typedef logic signed [7:0]  q7_0_t;

  localparam q1_15_t MU_ONE = 16'h7FFF;
  localparam int     NUM_W  = 26;
  localparam int     DEN_W  = 18;

  typedef enum logic [1:0] {IDLE, ACC, DIV, DONE} defuzz_state_t;

  // Strengths at or above 1.0 are pinned just below it.
  function automatic q1_15_t mu_sat(input q1_15_t m);
    return m[15] ? MU_ONE : m;
  endfunction
endpackage

// File: rtl/defuzzifier_seq_if.sv
// Input/output handshake bundle of defuzzifier_seq.
// DEFUZZ_DIAG_EN adds the sat_in / mu_sum diagnostic signals.
interface defuzzifier_seq_if;
  import fuzzy_pkg::*;

  logic   in_valid;
  logic   in_ready;
  q1_15_t mu_neg, mu_zero, mu_pos;
  q7_0_t  s_neg, s_zero, s_pos;
  logic   out_valid;
  logic   out_ready;
  q7_0_t  y;
  logic   no_rule;
`ifdef DEFUZZ_DIAG_EN
  logic             sat_in;
  logic [DEN_W-1:0] mu_sum;

  modport slave (input  in_valid, mu_neg, mu_zero, mu_pos, s_neg, s_zero, s_pos, out_ready,
                 output in_ready, out_valid, y, no_rule, sat_in, mu_sum);
  modport master(output in_valid, mu_neg, mu_zero, mu_pos, s_neg, s_zero, s_pos, out_ready,
                 input  in_ready, out_valid, y, no_rule, sat_in, mu_sum);
`else
  modport slave (input  in_valid, mu_neg, mu_zero, mu_pos, s_neg, s_zero, s_pos, out_ready,
                 output in_ready, out_valid, y, no_rule);
  modport master(output in_valid, mu_neg, mu_zero, mu_pos, s_neg, s_zero, s_pos, out_ready,
                 input  in_ready, out_valid, y, no_rule);
`endif
endinterface

// File: rtl/seq_divider_u.sv
// Restoring divider: one quotient bit per cycle, MSB first, Q_ITER-bit quotient of mag/den.
module seq_divider_u #(
  parameter int Q_ITER = 9,
  parameter int MAG_W  = 26,
  parameter int DEN_W  = 18
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic [MAG_W-1:0]  mag_i,
  input  logic [DEN_W-1:0]  den_i,
  output logic              done_o,
  output logic [Q_ITER-1:0] quo_o
);
  localparam int CW = $clog2(Q_ITER + 1);

  logic [DEN_W-1:0]  rem_q, dsr_q;
  logic [Q_ITER-2:0] dvd_q;
  logic [Q_ITER-1:0] quo_q;
  logic [CW-1:0]     cnt_q;
  logic              done_q, ovf_q;

  logic [DEN_W-1:0]  rem_src, dsr_src;
  logic              bit_src, ge;
  logic [DEN_W:0]    trial, rem_nxt;

  // The start cycle already performs the first iteration, straight from mag_i.
  always_comb begin
    rem_src = start_i ? DEN_W'(mag_i[MAG_W-1:Q_ITER]) : rem_q;
    bit_src = start_i ? mag_i[Q_ITER-1] : dvd_q[Q_ITER-2];
    dsr_src = start_i ? den_i : dsr_q;
    trial   = {rem_src, bit_src};
    ge      = (trial >= {1'b0, dsr_src});
    rem_nxt = ge ? (trial - {1'b0, dsr_src}) : trial;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q  <= '0;
      dsr_q  <= '0;
      dvd_q  <= '0;
      quo_q  <= '0;
      cnt_q  <= '0;
      done_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else if (start_i) begin
      rem_q  <= DEN_W'(rem_nxt);
      dsr_q  <= den_i;
      dvd_q  <= mag_i[Q_ITER-2:0];
      quo_q  <= {{(Q_ITER-1){1'b0}}, ge};
      cnt_q  <= CW'(Q_ITER - 1);
      done_q <= 1'b0;
      ovf_q  <= (DEN_W'(mag_i[MAG_W-1:Q_ITER]) >= den_i);
    end else if (cnt_q != '0) begin
      rem_q  <= DEN_W'(rem_nxt);
      dvd_q  <= {dvd_q[Q_ITER-3:0], 1'b0};
      quo_q  <= {quo_q[Q_ITER-2:0], ge};
      cnt_q  <= cnt_q - 1'b1;
      done_q <= (cnt_q == CW'(1));
    end else begin
      done_q <= 1'b0;
    end
  end

  assign done_o = done_q;
  assign quo_o  = ovf_q ? '1 : quo_q;
endmodule

// File: rtl/defuzzifier_seq.sv
// Sequential centroid defuzzifier: y = round(sum(mu_i*s_i) / sum(mu_i)) with serial MAC and divider.
// Optional diagnostics (sat_in, mu_sum) are enabled by DEFUZZ_DIAG_EN.
module defuzzifier_seq
  import fuzzy_pkg::*;
#(
  parameter int N_TERMS   = 3,
  parameter int Q_ITER    = 9,
  parameter int DEFAULT_Y = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  defuzzifier_seq_if.slave   bus
);
  defuzz_state_t           state_q;
  q1_15_t                  mu_q [N_TERMS];
  q7_0_t                   s_q  [N_TERMS];
  logic [1:0]              idx_q;
  logic signed [NUM_W-1:0] num_q;
  logic [DEN_W-1:0]        den_q;
  logic                    neg_q;
  logic                    in_ready_q, out_valid_q, no_rule_q;
  q7_0_t                   y_q;
`ifdef DEFUZZ_DIAG_EN
  logic                    sat_q;
  logic [DEN_W-1:0]        mu_sum_q;
`endif

  q1_15_t                  mu_sel;
  q7_0_t                   s_sel;
  logic signed [NUM_W-1:0] prod;
  logic [NUM_W-1:0]        abs_num, mag;
  logic                    div_start, div_done;
  logic [Q_ITER-1:0]       quo, quo_neg;
  q7_0_t                   y_div;

  always_comb begin
    mu_sel = '0;
    s_sel  = '0;
    case (idx_q)
      2'd0: begin mu_sel = mu_q[0]; s_sel = s_q[0]; end
      2'd1: begin mu_sel = mu_q[1]; s_sel = s_q[1]; end
      2'd2: begin mu_sel = mu_q[2]; s_sel = s_q[2]; end
      default: ;
    endcase
    prod    = NUM_W'($signed({1'b0, mu_sel})) * NUM_W'(s_sel);
    abs_num = num_q[NUM_W-1] ? NUM_W'(-num_q) : NUM_W'(num_q);
    mag     = abs_num + NUM_W'(den_q >> 1);
    quo_neg = '0 - quo;
    if (neg_q) y_div = (quo > Q_ITER'(128)) ? q7_0_t'(8'h80) : q7_0_t'(quo_neg[7:0]);
    else       y_div = (quo > Q_ITER'(127)) ? q7_0_t'(8'h7F) : q7_0_t'(quo[7:0]);
  end

  // ACC spends one extra cycle (idx == N_TERMS) so the den==0 decision sees the final sum.
  assign div_start = (state_q == ACC) && (idx_q == 2'(N_TERMS)) && (den_q != '0);

  seq_divider_u #(.Q_ITER(Q_ITER), .MAG_W(NUM_W), .DEN_W(DEN_W)) u_div (
    .clk     (clk),
    .rst_n   (rst_n),
    .start_i (div_start),
    .mag_i   (mag),
    .den_i   (den_q),
    .done_o  (div_done),
    .quo_o   (quo)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      for (int unsigned i = 0; i < N_TERMS; i++) begin
        mu_q[i] <= '0;
        s_q[i]  <= '0;
      end
      idx_q       <= '0;
      num_q       <= '0;
      den_q       <= '0;
      neg_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      no_rule_q   <= 1'b0;
      y_q         <= '0;
`ifdef DEFUZZ_DIAG_EN
      sat_q       <= 1'b0;
      mu_sum_q    <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: if (bus.in_valid) begin
          mu_q[0]    <= mu_sat(bus.mu_neg);
          mu_q[1]    <= mu_sat(bus.mu_zero);
          mu_q[2]    <= mu_sat(bus.mu_pos);
          s_q[0]     <= bus.s_neg;
          s_q[1]     <= bus.s_zero;
          s_q[2]     <= bus.s_pos;
          idx_q      <= '0;
          num_q      <= '0;
          den_q      <= '0;
          in_ready_q <= 1'b0;
`ifdef DEFUZZ_DIAG_EN
          sat_q      <= bus.mu_neg[15] | bus.mu_zero[15] | bus.mu_pos[15];
`endif
          state_q    <= ACC;
        end
        ACC: if (idx_q == 2'(N_TERMS)) begin
          if (den_q == '0) begin
            y_q         <= q7_0_t'(DEFAULT_Y);
            no_rule_q   <= 1'b1;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end else begin
            neg_q       <= num_q[NUM_W-1];
            state_q     <= DIV;
          end
`ifdef DEFUZZ_DIAG_EN
          mu_sum_q      <= den_q;
`endif
        end else begin
          num_q <= num_q + prod;
          den_q <= den_q + DEN_W'(mu_sel);
          idx_q <= idx_q + 1'b1;
        end
        DIV: if (div_done) begin
          y_q         <= y_div;
          no_rule_q   <= 1'b0;
          out_valid_q <= 1'b1;
          state_q     <= DONE;
        end
        DONE: if (bus.out_ready) begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.y         = y_q;
  assign bus.no_rule   = no_rule_q;
`ifdef DEFUZZ_DIAG_EN
  assign bus.sat_in    = sat_q;
  assign bus.mu_sum    = mu_sum_q;
`endif
endmodule

// File: doc/defuzzifier_seq.md
Name: defuzzifier_seq

Overview:
- Sequential centroid (weighted-average) defuzzifier at the output end of the fuzzy controller. It is the inverse direction of the dT fuzzifier.
- Takes three aggregated rule strengths (Q1.15) with their output singleton positions (Q7.0 signed). Produces one crisp Q7.0 control value: y = Σ(mu_i·s_i) / Σ(mu_i), rounded.
- Uses a valid/ready handshake on both sides, a serial multiply-accumulate, and an iterative restoring divider.

Parameters:
- N_TERMS, 3, number of output singletons (neg/zero/pos); fixed at 3 for this revision.
- Q_ITER, 9, restoring-divider iterations (quotient magnitude bits).
- DEFAULT_Y, 0, signed Q7.0 output when every mu is 0.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  input bundle valid
- in_ready  out  1  block can accept a bundle
- mu_neg, mu_zero, mu_pos  in  16 each  rule strengths, Q1.15 unsigned
- s_neg, s_zero, s_pos  in  8 each  singleton positions, signed Q7.0
- out_valid  out  1  y valid
- out_ready  in  1  consumer accepts y
- y  out  8  signed Q7.0 crisp output
- no_rule  out  1  high with out_valid when Σmu == 0

Behaviour:
- Reset values: state=IDLE, in_ready=1, out_valid=0, y=0, no_rule=0, all accumulators 0.
- FSM states:
  - IDLE: in_ready=1. On in_valid&&in_ready, capture all inputs and go to ACC.
  - ACC: N_TERMS cycles, one term per cycle in the order neg, zero, pos. num += mu_i·s_i (26-bit signed); den += mu_i (18-bit unsigned).
  - Leaving ACC: if den==0, go to DONE with y=DEFAULT_Y and no_rule=1. Otherwise go to DIV.
  - DIV: take mag=|num| + (den>>1) for round-half-away-from-zero. Run Q_ITER restoring iterations, one quotient bit per cycle, MSB first. At the end, apply the sign of num, clamp to [-128,127], and go to DONE.
  - DONE: out_valid=1. y and no_rule are held stable until out_ready. On out_valid&&out_ready, go to IDLE on the same edge, and out_valid drops on that edge.
- Capture rule: any mu with bit15 set saturates to 16'h7FFF at capture.
- Latency, counted in edges after the accepting edge:
  - out_valid rises after 1+N_TERMS+Q_ITER = 13 edges.
  - With den==0 it rises after 1+N_TERMS = 4 edges.
- No pipelining: in_ready=0 in every state except IDLE, and in_valid is ignored outside IDLE.
- out_ready held high continuously gives back-to-back operation. The next bundle is accepted in the cycle after the DONE→IDLE edge, so there is a one-idle-cycle gap.
- Reset asserted mid-operation immediately returns every register to its reset value and discards the partial result. No out_valid is produced for the aborted bundle.
- Quotient guarantee: valid inputs always satisfy |num| < den·2^8, so Q_ITER=9 is sufficient. The clamp is defensive only.

Optional Feature:
- Macro DEFUZZ_DIAG_EN.
- Defined: adds output port sat_in (1 bit), high with out_valid when any mu was saturated at capture. Also adds output port mu_sum (18 bits), equal to the final den. Both ports are held with y and reset to 0.
- Undefined: neither port exists. Saturation at capture still happens, silently.

Decomposition:
- fuzzy_pkg holds:
  - typedef q1_15_t (logic [15:0]) and typedef q7_0_t (logic signed [7:0]).
  - localparam MU_ONE = 16'h7FFF.
  - NUM_W=26 and DEN_W=18.
  - The FSM enum defuzz_state_t {IDLE, ACC, DIV, DONE}.
- One sub-module, seq_divider_u: start/done restoring divider over mag/den producing a Q_ITER-bit quotient, instantiated once.

Test Plan:
- mu=(0,7FFF,0), s=(-100,0,100) -> y=0, no_rule=0, out_valid exactly 13 edges after accept.
- mu=(0,4000,4000), s=(-100,0,100) -> y=50; mu=(2000,6000,0), same s -> y=-25.
- Rounding: mu=(0,1,1), s_pos=1 -> y=1 (0.5 rounds up); mu=(1,1,0), s_neg=-1 -> y=-1; mu=(0,2,1), s_pos=100 -> y=33.
- mu=(0,0,0) -> y=DEFAULT_Y(0), no_rule=1, out_valid after 4 edges.
- Backpressure: out_ready=0 for 20 cycles -> y stable, in_ready=0, a new in_valid is ignored. Releasing out_ready returns to IDLE with one idle cycle. Then: mu=(8000,0,0), s_neg=-128 -> y=-128, sat_in=1 when DEFUZZ_DIAG_EN is defined.
- Assert rst_n low during DIV -> out_valid=0, in_ready=1 immediately. A fresh bundle after release computes correctly.
